// File: rtl/gmii_tx_sched.sv
// Packet scheduler for one gmii_tx framer shared by a video FIFO and an aux FIFO.
// Grants one source per packet (round-robin), muxes FIFO data and holds the inter-frame gap.
module gmii_tx_sched #(
  parameter int CW            = 11,
  parameter int VID_PKT_WORDS = 400,
  parameter int AUX_MAX_WORDS = 64,
  parameter int IFG_CYCLES    = 12,
  parameter int START_TO      = 32
) (
  input  logic          tx_clk,
  input  logic          sys_rst_n,
  input  logic          enable,
  input  logic [CW-1:0] vid_count,
  input  logic          vid_empty,
  input  logic [23:0]   vid_dout,
  output logic          vid_rd_en,
  input  logic [CW-1:0] aux_count,
  input  logic          aux_empty,
  input  logic [23:0]   aux_dout,
  output logic          aux_rd_en,
  output logic          fr_start,
  output logic          fr_src,
  output logic [11:0]   fr_len,
  output logic [15:0]   fr_seq,
  input  logic          fr_busy,
  input  logic          fr_done,
  input  logic          fr_rd_en,
  output logic [23:0]   fr_dout,
  output logic          fr_empty,
  output logic          err_to
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_SEND, S_IFG} state_t;

  state_t      state, state_nxt;
  logic        last_src;
  logic [15:0] vid_seq, aux_seq;
  logic [11:0] words_rd;
  logic [15:0] timer;

  logic        vid_ok, aux_ok, grant, pick_aux;
  logic        timeout_hit, ifg_hit, rd_ok;
  logic [11:0] aux_len;

  assign vid_ok   = vid_count >= CW'(VID_PKT_WORDS);
  assign aux_ok   = (aux_count != '0) && !aux_empty;
  assign grant    = enable && (vid_ok || aux_ok);
  // With both eligible the source that lost the previous grant wins.
  assign pick_aux = aux_ok && (!vid_ok || !last_src);
  assign aux_len  = (aux_count > CW'(AUX_MAX_WORDS)) ? 12'(AUX_MAX_WORDS) : 12'(aux_count);

  assign timeout_hit = (state == S_WAIT) && !fr_busy && (timer == 16'(START_TO - 1));
  assign ifg_hit     = (timer == 16'(IFG_CYCLES - 1));
  assign rd_ok       = fr_rd_en && (words_rd < fr_len);

  // NOTE: state and datapath registers use non-blocking assignments so every
  // flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge tx_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= S_IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    // NOTE: defaults first, so no path through the case leaves an output
    // unassigned and no latch is inferred.
    state_nxt = state;
    fr_start  = 1'b0;
    vid_rd_en = 1'b0;
    aux_rd_en = 1'b0;
    fr_dout   = '0;
    fr_empty  = 1'b1;
    case (state)
      S_IDLE:  if (grant) state_nxt = S_START;
      S_START: begin
        fr_start  = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (fr_busy)          state_nxt = S_SEND;
        else if (timeout_hit) state_nxt = S_IFG;
      end
      S_SEND: begin
        vid_rd_en = rd_ok && !fr_src && !vid_empty;
        aux_rd_en = rd_ok &&  fr_src && !aux_empty;
        fr_dout   = fr_src ? aux_dout : vid_dout;
        fr_empty  = (words_rd == fr_len) || (fr_src ? aux_empty : vid_empty);
        if (fr_done) state_nxt = S_IFG;
      end
      S_IFG:   if (ifg_hit) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge tx_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      fr_src   <= 1'b0;
      fr_len   <= '0;
      fr_seq   <= '0;
      err_to   <= 1'b0;
      last_src <= 1'b1;  // makes video the first winner after reset
      vid_seq  <= '0;
      aux_seq  <= '0;
      words_rd <= '0;
      timer    <= '0;
    end else begin
      if (vid_rd_en || aux_rd_en) words_rd <= words_rd + 12'd1;
      case (state)
        S_IDLE: begin
          if (grant) begin
            fr_src   <= pick_aux;
            fr_len   <= pick_aux ? aux_len : 12'(VID_PKT_WORDS);
            fr_seq   <= pick_aux ? aux_seq : vid_seq;
            last_src <= pick_aux;
          end
        end
        S_START: begin
          if (fr_src) aux_seq <= aux_seq + 16'd1;
          else        vid_seq <= vid_seq + 16'd1;
          words_rd <= '0;
          timer    <= '0;
        end
        S_WAIT: begin
          if (!fr_busy) begin
            timer <= timeout_hit ? 16'd0 : timer + 16'd1;
            if (timeout_hit) err_to <= 1'b1;
          end
        end
        S_SEND: if (fr_done) timer <= '0;
        S_IFG: begin
          if (ifg_hit) begin
            timer  <= '0;
            fr_src <= 1'b0;
            fr_len <= '0;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gmii_tx_sched.sv
// Self-checking bench for gmii_tx_sched: randomized framer read pacing and FIFO levels
// checked against a grant/sequence/length model built from the scheduling rules.
module tb_gmii_tx_sched;

  localparam int VID_PKT  = 400;
  localparam int AUX_MAX  = 64;
  localparam int IFG      = 12;
  localparam int START_TO = 32;

  logic        tx_clk = 1'b0;
  logic        sys_rst_n, enable;
  logic [10:0] vid_count, aux_count;
  logic        vid_empty, aux_empty;
  logic [23:0] vid_dout, aux_dout;
  logic        vid_rd_en, aux_rd_en;
  logic        fr_start, fr_src;
  logic [11:0] fr_len;
  logic [15:0] fr_seq;
  logic        fr_busy, fr_done, fr_rd_en;
  logic [23:0] fr_dout;
  logic        fr_empty, err_to;

  always #4 tx_clk = ~tx_clk;

  gmii_tx_sched #(
    .CW(11), .VID_PKT_WORDS(VID_PKT), .AUX_MAX_WORDS(AUX_MAX),
    .IFG_CYCLES(IFG), .START_TO(START_TO)
  ) dut (
    .tx_clk(tx_clk), .sys_rst_n(sys_rst_n), .enable(enable),
    .vid_count(vid_count), .vid_empty(vid_empty), .vid_dout(vid_dout), .vid_rd_en(vid_rd_en),
    .aux_count(aux_count), .aux_empty(aux_empty), .aux_dout(aux_dout), .aux_rd_en(aux_rd_en),
    .fr_start(fr_start), .fr_src(fr_src), .fr_len(fr_len), .fr_seq(fr_seq),
    .fr_busy(fr_busy), .fr_done(fr_done), .fr_rd_en(fr_rd_en),
    .fr_dout(fr_dout), .fr_empty(fr_empty), .err_to(err_to)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Bench state: cycle counter, FIFO heads, framer model, reference model.
  int          cyc, n_starts, n_done_pkts, stray_rd;
  logic [15:0] vid_head, aux_head;
  bit          fm_active, fm_busy_en;
  int          fm_reqs_left, fm_reqs_total, fm_req_override;
  bit          n_busy, n_rd_en, n_done;
  int          pkt_rd[2];
  int          pkt_bad, pkt_len;
  bit          pkt_src, empty_checked;
  int          done_cyc, start_cyc;
  bit          prev_start, el_vid, el_aux, el_en;
  int          el_auxcnt;
  int          seq_ref[2];
  bit          last_ref, exp_err;
  bit          grant_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic set_counts(input int v, input int a);
    vid_count = 11'(v);
    aux_count = 11'(a);
    vid_empty = (v == 0);
    aux_empty = (a == 0);
  endtask

  task automatic model_init();
    n_starts = 0; n_done_pkts = 0;
    fm_active = 1'b0; fm_busy_en = 1'b1; fm_req_override = 0;
    n_busy = 1'b0; n_rd_en = 1'b0; n_done = 1'b0;
    pkt_rd = '{0, 0}; pkt_bad = 0; empty_checked = 1'b0;
    done_cyc = -1; start_cyc = 0;
    prev_start = 1'b0; el_vid = 1'b0; el_aux = 1'b0; el_en = 1'b0; el_auxcnt = 0;
    seq_ref = '{0, 0}; last_ref = 1'b1; exp_err = 1'b0;
    grant_q.delete();
  endtask

  task automatic apply_reset();
    sys_rst_n = 1'b0;
    enable = 1'b0;
    fr_busy = 1'b0; fr_rd_en = 1'b0; fr_done = 1'b0;
    set_counts(0, 0);
    model_init();
    repeat (3) @(posedge tx_clk);
    #1 sys_rst_n = 1'b1;
  endtask

  // One clock: sample at the falling edge, update models, drive just after the rising edge.
  task automatic cycle();
    bit rs;
    int rl;
    @(negedge tx_clk);
    cyc++;
    if (fr_start) begin
      check("start_pulse", prev_start, 0);
      check("grant_allowed", el_en && (el_vid || el_aux), 1);
      rs = (el_vid && el_aux) ? !last_ref : el_aux;
      rl = rs ? ((el_auxcnt > AUX_MAX) ? AUX_MAX : el_auxcnt) : VID_PKT;
      check("fr_src", fr_src, rs);
      check("fr_len", fr_len, rl);
      check("fr_seq", fr_seq, seq_ref[rs] & 16'hFFFF);
      seq_ref[rs]++;
      last_ref = rs;
      grant_q.push_back(rs);
      if (done_cyc >= 0) check("ifg_gap", (cyc - done_cyc) >= IFG + 2, 1);
      done_cyc = -1;
      start_cyc = cyc;
      n_starts++;
      fm_active = 1'b1;
      pkt_src = rs;
      pkt_len = rl;
      fm_reqs_total = (fm_req_override > 0) ? fm_req_override : rl;
      fm_reqs_left = fm_reqs_total;
      pkt_rd = '{0, 0};
      pkt_bad = 0;
      empty_checked = 1'b0;
    end
    prev_start = fr_start;
    if (fm_active && !fr_start && !empty_checked && pkt_rd[pkt_src] == pkt_len) begin
      check("empty_at_len", fr_empty, 1);
      empty_checked = 1'b1;
    end
    if (vid_rd_en) begin
      if (!fm_active) stray_rd++;
      else if (fr_dout !== {8'h56, vid_head}) pkt_bad++;
      vid_head++;
      pkt_rd[0]++;
    end
    if (aux_rd_en) begin
      if (!fm_active) stray_rd++;
      else if (fr_dout !== {8'hA5, aux_head}) pkt_bad++;
      aux_head++;
      pkt_rd[1]++;
    end
    n_done = 1'b0;
    if (fm_active && fr_done) begin
      check("src_reads", pkt_rd[pkt_src], (fm_reqs_total < pkt_len) ? fm_reqs_total : pkt_len);
      check("other_src_reads", pkt_rd[!pkt_src], 0);
      check("read_data", pkt_bad, 0);
      check("src_stable", fr_src, pkt_src);
      check("len_stable", fr_len, pkt_len);
      check("err_to", err_to, exp_err);
      done_cyc = cyc;
      fm_active = 1'b0;
      n_busy = 1'b0;
      n_rd_en = 1'b0;
      n_done_pkts++;
    end else if (fm_active && fr_start) begin
      n_busy = fm_busy_en;
      n_rd_en = 1'b0;
    end else if (fm_active && fm_busy_en) begin
      if (fr_rd_en) fm_reqs_left--;
      n_busy = 1'b1;
      if (fm_reqs_left == 0) begin
        n_rd_en = 1'b0;
        n_done = 1'b1;
      end else if (fm_reqs_left == 1 && ($urandom % 2) == 1) begin
        n_rd_en = 1'b1;  // final request and fr_done in the same cycle
        n_done = 1'b1;
      end else begin
        n_rd_en = ($urandom % 4) != 0;
      end
    end
    el_vid = vid_count >= VID_PKT;
    el_aux = (aux_count != 0) && !aux_empty;
    el_en = enable;
    el_auxcnt = int'(aux_count);
    @(posedge tx_clk);
    #1;
    fr_busy = n_busy;
    fr_rd_en = n_rd_en;
    fr_done = n_done;
    vid_dout = {8'h56, vid_head};
    aux_dout = {8'hA5, aux_head};
  endtask

  task automatic run_until_done(input int target, input int max_cyc);
    int k = 0;
    while (n_done_pkts < target && k < max_cyc) begin
      cycle();
      k++;
    end
    check("done_within_bound", n_done_pkts >= target, 1);
  endtask

  task automatic wait_starts(input int target, input int max_cyc);
    int k = 0;
    while (n_starts < target && k < max_cyc) begin
      cycle();
      k++;
    end
    check("start_within_bound", n_starts >= target, 1);
  endtask

  task automatic wait_vid_reads(input int target, input int max_cyc);
    int k = 0;
    while (pkt_rd[0] < target && k < max_cyc) begin
      cycle();
      k++;
    end
    check("reads_within_bound", pkt_rd[0] >= target, 1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_fr_start"}, fr_start, 0);
    check({tag, "_vid_rd_en"}, vid_rd_en, 0);
    check({tag, "_aux_rd_en"}, aux_rd_en, 0);
    check({tag, "_fr_src"}, fr_src, 0);
    check({tag, "_fr_len"}, fr_len, 0);
    check({tag, "_fr_seq"}, fr_seq, 0);
    check({tag, "_fr_dout"}, fr_dout, 0);
    check({tag, "_fr_empty"}, fr_empty, 1);
    check({tag, "_err_to"}, err_to, 0);
  endtask

  initial begin
    #700_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t4_first, s0, v, a;
    cyc = 0; stray_rd = 0; vid_head = 16'h0000; aux_head = 16'h8000;
    vid_dout = {8'h56, vid_head};
    aux_dout = {8'hA5, aux_head};

    // Reset state
    apply_reset();
    check_idle_outputs("rst_hold");
    cycle();
    check_idle_outputs("rst_idle");

    // 1: single video packet, grant one cycle after eligibility
    enable = 1'b1;
    set_counts(400, 0);
    cycle();
    check("t1_no_start_yet", n_starts, 0);
    cycle();
    check("t1_start_latency", n_starts, 1);
    enable = 1'b0;
    run_until_done(1, 2000);

    // 2: both sources eligible alternate starting with video
    apply_reset();
    enable = 1'b1;
    set_counts(500, 10);
    run_until_done(3, 4000);
    enable = 1'b0;
    check("t2_grants", grant_q.size(), 3);
    if (grant_q.size() == 3) begin
      check("t2_grant0", grant_q[0], 0);
      check("t2_grant1", grant_q[1], 1);
      check("t2_grant2", grant_q[2], 0);
    end

    // 3: aux length capped, excess framer requests suppressed
    apply_reset();
    fm_req_override = 70;
    enable = 1'b1;
    set_counts(0, 100);
    run_until_done(1, 1000);
    enable = 1'b0;
    fm_req_override = 0;

    // 4: framer never busy -> start timeout, sticky error, regrant after IFG
    apply_reset();
    fm_busy_en = 1'b0;
    enable = 1'b1;
    set_counts(400, 0);
    wait_starts(1, 20);
    t4_first = start_cyc;
    while (cyc < t4_first + START_TO - 1) cycle();
    check("t4_err_before", err_to, 0);
    cycle();
    check("t4_err_after", err_to, 1);
    exp_err = 1'b1;
    fm_busy_en = 1'b1;
    fm_active = 1'b0;
    wait_starts(2, 60);
    check("t4_regrant_gap", start_cyc - t4_first, START_TO + IFG + 2);
    run_until_done(1, 2000);
    enable = 1'b0;

    // 5: reset mid-packet
    apply_reset();
    enable = 1'b1;
    set_counts(400, 0);
    wait_vid_reads(200, 1000);
    sys_rst_n = 1'b0;
    #1;
    check_idle_outputs("t5_async");
    model_init();
    fr_busy = 1'b0; fr_rd_en = 1'b0; fr_done = 1'b0;
    repeat (2) @(posedge tx_clk);
    #1 sys_rst_n = 1'b1;
    enable = 1'b1;
    run_until_done(1, 2000);
    enable = 1'b0;
    check("t5_first_src", grant_q.size() > 0 ? grant_q[0] : 1'b1, 0);

    // 6: enable dropped during SEND
    apply_reset();
    enable = 1'b1;
    set_counts(400, 0);
    wait_vid_reads(50, 1000);
    enable = 1'b0;
    run_until_done(1, 2000);
    s0 = n_starts;
    repeat (60) cycle();
    check("t6_held_idle", n_starts, s0);
    enable = 1'b1;
    wait_starts(s0 + 1, 10);
    run_until_done(2, 2000);
    enable = 1'b0;

    // 7: random FIFO levels
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      v = $urandom_range(600, 300);
      a = $urandom_range(80, 0);
      if (v < VID_PKT && a == 0) a = 1;
      set_counts(v, a);
      enable = 1'b1;
      run_until_done(n_done_pkts + 2, 3000);
    end
    enable = 1'b0;
    repeat (20) cycle();

    check("stray_reads", stray_rd, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
